// File: rtl/adder_tree_pipe_if.sv
// Stream bundle for the pipelined adder tree: product vector in, scaled sample out,
// plus the saturation-event counter controls.
interface adder_tree_pipe_if #(
  parameter int unsigned TAPS     = 401,
  parameter int unsigned MULTBITS = 32,
  parameter int unsigned OUTBITS  = 32
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [MULTBITS-1:0] products [0:TAPS-1];
  logic                       out_valid;
  logic                       out_ready;
  logic signed [OUTBITS-1:0]  out_data;
  logic                       out_sat;
  logic                       sat_clr;
  logic [15:0]                sat_count;

  modport master (
    output in_valid, products, out_ready, sat_clr,
    input  in_ready, out_valid, out_data, out_sat, sat_count
  );

  modport slave (
    input  in_valid, products, out_ready, sat_clr,
    output in_ready, out_valid, out_data, out_sat, sat_count
  );
endinterface

// File: rtl/adder_tree_pipe.sv
// Fully pipelined signed adder tree with configurable register spacing, ready/valid
// backpressure, round-half-up scaling, optional saturation and a saturation counter.
module adder_tree_pipe #(
  parameter int unsigned TAPS      = 401,
  parameter int unsigned MULTBITS  = 32,
  parameter int unsigned OUTBITS   = 32,
  parameter int unsigned SHIFT     = 0,
  parameter bit          SATURATE  = 1'b1,
  parameter int unsigned REG_EVERY = 1
) (
  input logic               clk,
  input logic               rst_n,
  adder_tree_pipe_if.slave  tap_if
);

  localparam int unsigned LEVELS   = $clog2(TAPS);
  localparam int unsigned ACCUBITS = MULTBITS + LEVELS;
  localparam int unsigned STAGES   = (LEVELS + REG_EVERY - 1) / REG_EVERY;
  localparam int unsigned NLEAF    = 1 << LEVELS;
  localparam int unsigned NNODE    = 2 * NLEAF - 1;
  localparam int unsigned RW       = ACCUBITS + 1;

  localparam logic [RW-1:0] ONE  = RW'(1);
  localparam logic [RW-1:0] HALF = (ONE << SHIFT) >> 1;
  localparam logic [RW-1:0] MAXV = (ONE << (OUTBITS - 1)) - ONE;
  localparam logic [RW-1:0] MINV = ~MAXV;

  // Nodes are stored level by level: leaves first, root last.
  function automatic int unsigned lvl_off(int unsigned l);
    return 2 * NLEAF - 2 * (NLEAF >> l);
  endfunction

  logic signed [ACCUBITS-1:0] w_node [NNODE];
  logic [STAGES:0]            r_valid;
  logic                       w_stall;
  logic                       w_adv;
  logic                       r_out_valid;
  logic                       r_out_sat;
  logic [OUTBITS-1:0]         r_out_data;
  logic [15:0]                r_sat_count;
  logic signed [RW-1:0]       w_ext;
  logic signed [RW-1:0]       w_rnd;
  logic signed [RW-1:0]       w_r;
  logic [OUTBITS-1:0]         w_data;
  logic                       w_sat;
  logic                       w_deliver;

  assign w_stall         = r_out_valid && !tap_if.out_ready;
  assign w_adv           = !w_stall;
  assign tap_if.in_ready = w_adv;
  assign w_deliver       = r_out_valid && tap_if.out_ready;

  // Products are captured on accept; unused leaves of the power-of-two tree read as zero.
  for (genvar j = 0; j < NLEAF; j++) begin : g_leaf
    if (j < TAPS) begin : g_tap
      logic signed [MULTBITS-1:0] r_prod;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_prod <= '0;
        end else if (w_adv) begin
          r_prod <= tap_if.products[j];
        end
      end
      assign w_node[j] = {{LEVELS{r_prod[MULTBITS-1]}}, r_prod};
    end else begin : g_pad
      assign w_node[j] = '0;
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned CNT    = NLEAF >> l;
    localparam bit          IS_REG = ((l % REG_EVERY) == 0) || (l == LEVELS);
    for (genvar j = 0; j < CNT; j++) begin : g_node
      logic signed [ACCUBITS-1:0] w_sum;
      assign w_sum = w_node[lvl_off(l - 1) + 2 * j] + w_node[lvl_off(l - 1) + 2 * j + 1];
      if (IS_REG) begin : g_reg
        logic signed [ACCUBITS-1:0] r_sum;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_sum <= '0;
          end else if (w_adv) begin
            r_sum <= w_sum;
          end
        end
        assign w_node[lvl_off(l) + j] = r_sum;
      end else begin : g_comb
        assign w_node[lvl_off(l) + j] = w_sum;
      end
    end
  end

  // Bubbles travel with their stage; the whole pipe freezes on a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid <= {r_valid[STAGES-1:0], tap_if.in_valid};
    end
  end

  always_comb begin
    w_ext  = {w_node[NNODE-1][ACCUBITS-1], w_node[NNODE-1]};
    w_rnd  = w_ext + $signed(HALF);
    w_r    = w_rnd >>> SHIFT;
    w_data = w_r[OUTBITS-1:0];
    w_sat  = 1'b0;
    if (SATURATE) begin
      if (w_r > $signed(MAXV)) begin
        w_data = MAXV[OUTBITS-1:0];
        w_sat  = 1'b1;
      end else if (w_r < $signed(MINV)) begin
        w_data = MINV[OUTBITS-1:0];
        w_sat  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_valid[STAGES];
      r_out_data  <= w_data;
      r_out_sat   <= w_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (tap_if.sat_clr) begin
      r_sat_count <= '0;
    end else if (w_deliver && r_out_sat && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign tap_if.out_valid = r_out_valid;
  assign tap_if.out_data  = r_out_data;
  assign tap_if.out_sat   = r_out_sat;
  assign tap_if.sat_count = r_sat_count;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench: three tree configurations driven with directed and random beats,
// checked against an arithmetic model with expected-sample queues.
module tb_adder_tree_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  adder_tree_pipe_if #(.TAPS(5), .MULTBITS(8), .OUTBITS(8))  ifa ();
  adder_tree_pipe_if #(.TAPS(5), .MULTBITS(8), .OUTBITS(8))  ifw ();
  adder_tree_pipe_if #(.TAPS(8), .MULTBITS(8), .OUTBITS(11)) ifb ();

  adder_tree_pipe #(.TAPS(5), .MULTBITS(8), .OUTBITS(8), .SHIFT(2), .SATURATE(1'b1),
                    .REG_EVERY(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .tap_if(ifa));
  adder_tree_pipe #(.TAPS(5), .MULTBITS(8), .OUTBITS(8), .SHIFT(2), .SATURATE(1'b0),
                    .REG_EVERY(1)) u_dut_w (.clk(clk), .rst_n(rst_n), .tap_if(ifw));
  adder_tree_pipe #(.TAPS(8), .MULTBITS(8), .OUTBITS(11), .SHIFT(0), .SATURATE(1'b1),
                    .REG_EVERY(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .tap_if(ifb));

  int qa_d[$];
  bit qa_s[$];
  int qw_d[$];
  int qb_d[$];
  int cnt_a = 0;
  int hold_d = 0;
  bit hold_v = 1'b0;
  int stall_cnt = 0;
  int dlv_a = 0;

  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd(int sum, int shift);
    return (sum + ((1 << shift) >> 1)) >>> shift;
  endfunction

  function automatic int clamp(int r, int ob, output bit s);
    int mx = (1 << (ob - 1)) - 1;
    int mn = -(1 << (ob - 1));
    s = 1'b1;
    if (r > mx) return mx;
    if (r < mn) return mn;
    s = 1'b0;
    return r;
  endfunction

  function automatic int wrap8(int r);
    logic [31:0] t = r;
    return int'($signed(t[7:0]));
  endfunction

  task automatic drive_aw(int v, bit vld, bit rand_p);
    int p;
    for (int i = 0; i < 5; i++) begin
      p = rand_p ? int'($urandom_range(0, 255)) - 128 : v;
      ifa.products[i] = 8'(p);
      ifw.products[i] = 8'(p);
    end
    ifa.in_valid = vld;
    ifw.in_valid = vld;
  endtask

  task automatic set_ready_aw(bit r);
    ifa.out_ready = r;
    ifw.out_ready = r;
  endtask

  // One clock: check pending deliveries against the model, enqueue accepted beats.
  task automatic step();
    int sum;
    bit s;
    #1;
    chk("in_ready_a", ifa.in_ready, !(ifa.out_valid && !ifa.out_ready));
    chk("in_ready_b", ifb.in_ready, !(ifb.out_valid && !ifb.out_ready));
    if (!ifa.in_ready) stall_cnt++;
    if (hold_v) chk("hold_a", $signed(ifa.out_data), hold_d);
    hold_v = ifa.out_valid && !ifa.out_ready;
    hold_d = int'($signed(ifa.out_data));
    if (ifa.out_valid && ifa.out_ready) begin
      chk("pending_a", qa_d.size() != 0, 1);
      if (qa_d.size() != 0) begin
        s = qa_s.pop_front();
        chk("data_a", $signed(ifa.out_data), qa_d.pop_front());
        chk("sat_a", ifa.out_sat, s);
        if (s && cnt_a != 16'hFFFF) cnt_a++;
        dlv_a++;
      end
    end
    if (ifa.sat_clr) cnt_a = 0;
    if (ifw.out_valid && ifw.out_ready) begin
      chk("pending_w", qw_d.size() != 0, 1);
      if (qw_d.size() != 0) begin
        chk("data_w", $signed(ifw.out_data), qw_d.pop_front());
        chk("sat_w", ifw.out_sat, 0);
      end
    end
    if (ifb.out_valid && ifb.out_ready) begin
      chk("pending_b", qb_d.size() != 0, 1);
      if (qb_d.size() != 0) chk("data_b", $signed(ifb.out_data), qb_d.pop_front());
    end
    if (ifa.in_valid && ifa.in_ready) begin
      sum = 0;
      for (int i = 0; i < 5; i++) sum += int'(ifa.products[i]);
      qa_d.push_back(clamp(rnd(sum, 2), 8, s));
      qa_s.push_back(s);
    end
    if (ifw.in_valid && ifw.in_ready) begin
      sum = 0;
      for (int i = 0; i < 5; i++) sum += int'(ifw.products[i]);
      qw_d.push_back(wrap8(rnd(sum, 2)));
    end
    if (ifb.in_valid && ifb.in_ready) begin
      sum = 0;
      for (int i = 0; i < 8; i++) sum += int'(ifb.products[i]);
      qb_d.push_back(clamp(sum, 11, s));
    end
    @(posedge clk);
    #1;
    chk("sat_count_a", ifa.sat_count, cnt_a);
    chk("sat_count_w", ifw.sat_count, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (qa_d.size() + qw_d.size() + qb_d.size()) != 0; k++) step();
    chk("drain", qa_d.size() + qw_d.size() + qb_d.size(), 0);
  endtask

  initial begin
    int b_vec [8] = '{-128, 127, 1, 0, 5, -5, 100, -100};
    int d0;

    drive_aw(0, 1'b0, 1'b0);
    set_ready_aw(1'b1);
    ifa.sat_clr = 1'b0;
    ifw.sat_clr = 1'b0;
    for (int i = 0; i < 8; i++) ifb.products[i] = '0;
    ifb.in_valid  = 1'b0;
    ifb.out_ready = 1'b1;
    ifb.sat_clr   = 1'b0;

    #7;
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_sat_count", ifa.sat_count, 0);
    chk("rst_in_ready", ifa.in_ready, 1);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat of ones: (5+2)>>2 = 1, four edges after the accepting edge.
    drive_aw(1, 1'b1, 1'b0);
    step();
    drive_aw(0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("latency_a", ifa.out_valid, k == 4);
    end
    chk("first_data_a", $signed(ifa.out_data), 1);
    step();

    // Positive then negative saturation, then counter clear.
    drive_aw(127, 1'b1, 1'b0);
    step();
    drive_aw(-128, 1'b1, 1'b0);
    step();
    drive_aw(0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step();
    chk("sat_count_two", ifa.sat_count, 2);
    ifa.sat_clr = 1'b1;
    ifw.sat_clr = 1'b1;
    step();
    ifa.sat_clr = 1'b0;
    ifw.sat_clr = 1'b0;
    chk("sat_count_clr", ifa.sat_count, 0);

    // Ten-beat stream with a three-cycle downstream stall.
    stall_cnt = 0;
    d0 = dlv_a;
    begin
      int idx = 1;
      for (int c = 0; c < 30; c++) begin
        set_ready_aw(!(c >= 6 && c <= 8));
        if (idx <= 10) drive_aw(idx, 1'b1, 1'b0);
        else drive_aw(0, 1'b0, 1'b0);
        #1;
        if (ifa.in_valid && ifa.in_ready) idx++;
        step();
      end
    end
    set_ready_aw(1'b1);
    chk("stream_stalls", stall_cnt, 3);
    chk("stream_count", dlv_a - d0, 10);
    drain();

    // Asynchronous reset with samples in flight.
    for (int k = 0; k < 6; k++) begin
      drive_aw(127, 1'b1, 1'b0);
      step();
    end
    drive_aw(0, 1'b0, 1'b0);
    chk("pre_rst_valid", ifa.out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", ifa.out_valid, 0);
    chk("arst_out_data", $signed(ifa.out_data), 0);
    chk("arst_sat_count", ifa.sat_count, 0);
    chk("arst_in_ready", ifa.in_ready, 1);
    qa_d.delete();
    qa_s.delete();
    qw_d.delete();
    qb_d.delete();
    cnt_a  = 0;
    hold_v = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_aw(2, 1'b1, 1'b0);
    step();
    drive_aw(0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("latency_post_rst", ifa.out_valid, k == 4);
    end
    chk("post_rst_data", $signed(ifa.out_data), 3);
    step();

    // Random beats with random backpressure and occasional counter clears.
    for (int c = 0; c < 120; c++) begin
      drive_aw(0, 1'($urandom_range(0, 1)), 1'b1);
      set_ready_aw($urandom_range(0, 3) != 0);
      ifa.sat_clr = ($urandom_range(0, 15) == 0);
      ifw.sat_clr = ifa.sat_clr;
      step();
    end
    drive_aw(0, 1'b0, 1'b0);
    set_ready_aw(1'b1);
    ifa.sat_clr = 1'b0;
    ifw.sat_clr = 1'b0;
    drain();

    // Eight taps, two levels per register bank: three-edge latency, exact cancellation.
    for (int i = 0; i < 8; i++) ifb.products[i] = 8'(b_vec[i]);
    ifb.in_valid = 1'b1;
    step();
    ifb.in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("latency_b", ifb.out_valid, k == 3);
    end
    chk("data_b_zero", $signed(ifb.out_data), 0);
    step();
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 8; i++) ifb.products[i] = 8'($urandom_range(0, 255));
      ifb.in_valid  = 1'($urandom_range(0, 1));
      ifb.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    ifb.in_valid  = 1'b0;
    ifb.out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
